// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the P5 fetch-stage PC controller.
// Holds the next-PC select encodings, the memory window and the control FSM states.
package fetch_pc_ctrl_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } fsm_state_e;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int unsigned IM_WORDS = 4096;
   localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(4 * IM_WORDS);

   // A fetch PC is bad if it is misaligned or outside instruction memory.
   function automatic logic pc_is_bad(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc >= IM_LIMIT);
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch/decode-side signal bundle of the PC controller.
// The master side is the decode stage, hazard unit and fetch unit; the slave side is fetch_pc_ctrl.
interface fetch_pc_ctrl_if;
   import fetch_pc_ctrl_pkg::*;

   logic        stall_i;
   npc_sel_e    npc_sel_D_i;
   logic        br_taken_D_i;
   logic [15:0] imm16_D_i;
   logic [25:0] imm26_D_i;
   logic [31:0] jr_tgt_D_i;
   logic [31:0] instr_F_i;
   logic [31:0] pc_F_o;
   logic [31:0] instr_D_o;
   logic [31:0] pc_D_o;
   logic [31:0] pc8_D_o;
   logic [31:0] fetch_cnt_o;
   logic        fault_o;

   modport master (
      output stall_i, npc_sel_D_i, br_taken_D_i, imm16_D_i, imm26_D_i, jr_tgt_D_i, instr_F_i,
      input  pc_F_o, instr_D_o, pc_D_o, pc8_D_o, fetch_cnt_o, fault_o
   );

   modport slave (
      input  stall_i, npc_sel_D_i, br_taken_D_i, imm16_D_i, imm26_D_i, jr_tgt_D_i, instr_F_i,
      output pc_F_o, instr_D_o, pc_D_o, pc8_D_o, fetch_cnt_o, fault_o
   );

endinterface

// File: rtl/fetch_pc_ctrl_npc_calc.sv
// Combinational next-PC target selection; redirects are relative to the PC of the
// branch/jump in D, so the instruction currently in F is the delay slot.
module npc_calc
   import fetch_pc_ctrl_pkg::*;
(
   input  logic [31:0] pc_f_i,
   input  logic [31:0] pc_d_i,
   input  npc_sel_e    npc_sel_i,
   input  logic        br_taken_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] imm26_i,
   input  logic [31:0] jr_tgt_i,
   output logic [31:0] npc_o
);

   logic [31:0] seq_pc;
   logic [31:0] br_pc;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      seq_pc = pc_f_i + 32'd4;
      br_pc  = pc_d_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
      npc_o  = seq_pc;
      case (npc_sel_i)
         NPC_SEQ: npc_o = seq_pc;
         NPC_BR:  npc_o = br_taken_i ? br_pc : seq_pc;
         NPC_J:   npc_o = {pc_d_i[31:28], imm26_i, 2'b00};
         NPC_JR:  npc_o = jr_tgt_i;
         default: npc_o = seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// P5 fetch-stage PC register, F/D pipeline register, fetch counter and sticky fetch fault.
// Once a bad PC is loaded the PC freezes until reset while F/D keeps sampling its input.
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   fetch_pc_ctrl_if.slave bus
);

   fsm_state_e  state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_dec_q, pc_dec_d;
   logic [31:0] instr_dec_q, instr_dec_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        fault_q, fault_d;
   logic [31:0] npc;
   logic        advance;
   logic        load_pc;
   logic        new_fault;

   npc_calc u_npc_calc (
      .pc_f_i     (pc_f_q),
      .pc_d_i     (pc_dec_q),
      .npc_sel_i  (bus.npc_sel_D_i),
      .br_taken_i (bus.br_taken_D_i),
      .imm16_i    (bus.imm16_D_i),
      .imm26_i    (bus.imm26_D_i),
      .jr_tgt_i   (bus.jr_tgt_D_i),
      .npc_o      (npc)
   );

   always_comb begin
      advance     = !bus.stall_i;
      load_pc     = advance && (state_q == ST_RUN);
      new_fault   = load_pc && pc_is_bad(npc);
      pc_f_d      = load_pc ? npc : pc_f_q;
      pc_dec_d    = advance ? pc_f_q : pc_dec_q;
      instr_dec_d = advance ? bus.instr_F_i : instr_dec_q;
      fetch_cnt_d = advance ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
      fault_d     = fault_q | new_fault;
      state_d     = new_fault ? ST_FAULT : state_q;
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_f_q      <= RESET_PC;
         pc_dec_q    <= RESET_PC;
         instr_dec_q <= '0;
         fetch_cnt_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_f_q      <= pc_f_d;
         pc_dec_q    <= pc_dec_d;
         instr_dec_q <= instr_dec_d;
         fetch_cnt_q <= fetch_cnt_d;
         fault_q     <= fault_d;
      end
   end

   assign bus.pc_F_o      = pc_f_q;
   assign bus.pc_D_o      = pc_dec_q;
   assign bus.pc8_D_o     = pc_dec_q + 32'd8;
   assign bus.instr_D_o   = instr_dec_q;
   assign bus.fetch_cnt_o = fetch_cnt_q;
   assign bus.fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequential fetch, branch, jump, stall, jr fault,
// memory-window edges and reset priority, each checked against hand-computed values.
module tb_fetch_pc_ctrl;
   import fetch_pc_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_pc_ctrl_if bus ();

   fetch_pc_ctrl u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory stand-in: a recognisable word derived from the address.
   function automatic logic [31:0] imem(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   assign bus.instr_F_i = imem(bus.pc_F_o);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall_i      = 1'b0;
      bus.npc_sel_D_i  = NPC_SEQ;
      bus.br_taken_D_i = 1'b0;
      bus.imm16_D_i    = '0;
      bus.imm26_D_i    = '0;
      bus.jr_tgt_D_i   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic run_seq(input int n);
      idle_inputs();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.pc_F_o !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_F_o, 32'h3000); end
      checks++; if (bus.instr_D_o !== 32'h0) begin errors++; $display("FAIL reset_instr_d got=%h exp=%h", bus.instr_D_o, 32'h0); end
      checks++; if (bus.pc_D_o !== 32'h3000) begin errors++; $display("FAIL reset_pc_d got=%h exp=%h", bus.pc_D_o, 32'h3000); end
      checks++; if (bus.pc8_D_o !== 32'h3008) begin errors++; $display("FAIL reset_pc8 got=%h exp=%h", bus.pc8_D_o, 32'h3008); end
      checks++; if (bus.fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=%h", bus.fetch_cnt_o, 32'h0); end
      checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault_o); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [3] = '{32'h3004, 32'h3008, 32'h300C};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus.pc_F_o !== exp_pc[k]) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, bus.pc_F_o, exp_pc[k]); end
      end
      checks++; if (bus.fetch_cnt_o !== 32'd3) begin errors++; $display("FAIL seq_cnt got=%0d exp=3", bus.fetch_cnt_o); end
      checks++; if (bus.pc_D_o !== 32'h3008) begin errors++; $display("FAIL seq_pc_d got=%h exp=%h", bus.pc_D_o, 32'h3008); end
      checks++; if (bus.pc8_D_o !== 32'h3010) begin errors++; $display("FAIL seq_pc8 got=%h exp=%h", bus.pc8_D_o, 32'h3010); end
      checks++; if (bus.instr_D_o !== 32'hC0DE_3008) begin errors++; $display("FAIL seq_instr_d got=%h exp=%h", bus.instr_D_o, 32'hC0DE_3008); end
   endtask

   task automatic test_branch();
      do_reset();
      run_seq(5);  // pc_F=3014, pc_D=3010
      checks++; if (bus.pc_D_o !== 32'h3010) begin errors++; $display("FAIL br_setup_pc_d got=%h exp=%h", bus.pc_D_o, 32'h3010); end
      bus.npc_sel_D_i  = NPC_BR;
      bus.br_taken_D_i = 1'b1;
      bus.imm16_D_i    = 16'hFFFC;
      step();
      checks++; if (bus.pc_F_o !== 32'h3004) begin errors++; $display("FAIL br_taken_pc got=%h exp=%h", bus.pc_F_o, 32'h3004); end
      checks++; if (bus.instr_D_o !== 32'hC0DE_3014) begin errors++; $display("FAIL br_delay_slot got=%h exp=%h", bus.instr_D_o, 32'hC0DE_3014); end
      bus.br_taken_D_i = 1'b0;
      step();
      checks++; if (bus.pc_F_o !== 32'h3008) begin errors++; $display("FAIL br_not_taken_pc got=%h exp=%h", bus.pc_F_o, 32'h3008); end
      checks++; if (bus.fetch_cnt_o !== 32'd7) begin errors++; $display("FAIL br_cnt got=%0d exp=7", bus.fetch_cnt_o); end
   endtask

   task automatic test_jump();
      do_reset();
      run_seq(6);  // pc_F=3018, pc_D=3014
      bus.npc_sel_D_i = NPC_J;
      bus.imm26_D_i   = 26'h0000C40;
      step();
      checks++; if (bus.pc_F_o !== 32'h3100) begin errors++; $display("FAIL j_pc got=%h exp=%h", bus.pc_F_o, 32'h3100); end
      checks++; if (bus.instr_D_o !== 32'hC0DE_3018) begin errors++; $display("FAIL j_delay_slot got=%h exp=%h", bus.instr_D_o, 32'hC0DE_3018); end
      checks++; if (bus.pc8_D_o !== 32'h3020) begin errors++; $display("FAIL j_pc8 got=%h exp=%h", bus.pc8_D_o, 32'h3020); end
   endtask

   task automatic test_stall();
      do_reset();
      run_seq(6);  // pc_F=3018, pc_D=3014, cnt=6
      bus.stall_i     = 1'b1;
      bus.npc_sel_D_i = NPC_J;
      bus.imm26_D_i   = 26'h0000C40;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (bus.pc_F_o !== 32'h3018) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", k, bus.pc_F_o, 32'h3018); end
         checks++; if (bus.pc_D_o !== 32'h3014) begin errors++; $display("FAIL stall_pc_d[%0d] got=%h exp=%h", k, bus.pc_D_o, 32'h3014); end
         checks++; if (bus.instr_D_o !== 32'hC0DE_3014) begin errors++; $display("FAIL stall_instr_d[%0d] got=%h exp=%h", k, bus.instr_D_o, 32'hC0DE_3014); end
         checks++; if (bus.fetch_cnt_o !== 32'd6) begin errors++; $display("FAIL stall_cnt[%0d] got=%0d exp=6", k, bus.fetch_cnt_o); end
      end
      bus.stall_i = 1'b0;
      step();
      checks++; if (bus.pc_F_o !== 32'h3100) begin errors++; $display("FAIL stall_release_pc got=%h exp=%h", bus.pc_F_o, 32'h3100); end
      checks++; if (bus.fetch_cnt_o !== 32'd7) begin errors++; $display("FAIL stall_release_cnt got=%0d exp=7", bus.fetch_cnt_o); end
   endtask

   task automatic test_jr_fault();
      do_reset();
      run_seq(2);  // pc_F=3008, pc_D=3004
      bus.npc_sel_D_i = NPC_JR;
      bus.jr_tgt_D_i  = 32'h3002;
      step();
      checks++; if (bus.pc_F_o !== 32'h3002) begin errors++; $display("FAIL jr_pc got=%h exp=%h", bus.pc_F_o, 32'h3002); end
      checks++; if (bus.fault_o !== 1'b1) begin errors++; $display("FAIL jr_fault got=%b exp=1", bus.fault_o); end
      run_seq(2);
      checks++; if (bus.pc_F_o !== 32'h3002) begin errors++; $display("FAIL fault_hold_pc got=%h exp=%h", bus.pc_F_o, 32'h3002); end
      checks++; if (bus.fault_o !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", bus.fault_o); end
      checks++; if (bus.pc_D_o !== 32'h3002) begin errors++; $display("FAIL fault_fd_adv got=%h exp=%h", bus.pc_D_o, 32'h3002); end
      checks++; if (bus.fetch_cnt_o !== 32'd5) begin errors++; $display("FAIL fault_cnt got=%0d exp=5", bus.fetch_cnt_o); end
      do_reset();
      checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", bus.fault_o); end
      step();
      checks++; if (bus.pc_F_o !== 32'h3004) begin errors++; $display("FAIL fault_resume_pc got=%h exp=%h", bus.pc_F_o, 32'h3004); end
   endtask

   task automatic test_bounds();
      do_reset();
      bus.npc_sel_D_i = NPC_JR;
      bus.jr_tgt_D_i  = 32'h6FFC;
      step();
      checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL top_word_fault got=%b exp=0", bus.fault_o); end
      checks++; if (bus.pc_F_o !== 32'h6FFC) begin errors++; $display("FAIL top_word_pc got=%h exp=%h", bus.pc_F_o, 32'h6FFC); end
      run_seq(1);
      checks++; if (bus.pc_F_o !== 32'h7000) begin errors++; $display("FAIL limit_pc got=%h exp=%h", bus.pc_F_o, 32'h7000); end
      checks++; if (bus.fault_o !== 1'b1) begin errors++; $display("FAIL limit_fault got=%b exp=1", bus.fault_o); end
      do_reset();
      bus.npc_sel_D_i = NPC_JR;
      bus.jr_tgt_D_i  = 32'h2FFC;
      step();
      checks++; if (bus.fault_o !== 1'b1) begin errors++; $display("FAIL below_base_fault got=%b exp=1", bus.fault_o); end
   endtask

   task automatic test_reset_priority();
      do_reset();
      run_seq(6);
      bus.npc_sel_D_i  = NPC_BR;
      bus.br_taken_D_i = 1'b1;
      bus.imm16_D_i    = 16'hFFFC;
      bus.stall_i      = 1'b1;
      reset            = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (bus.pc_F_o !== 32'h3000) begin errors++; $display("FAIL rstpri_pc got=%h exp=%h", bus.pc_F_o, 32'h3000); end
      checks++; if (bus.pc_D_o !== 32'h3000) begin errors++; $display("FAIL rstpri_pc_d got=%h exp=%h", bus.pc_D_o, 32'h3000); end
      checks++; if (bus.instr_D_o !== 32'h0) begin errors++; $display("FAIL rstpri_instr_d got=%h exp=0", bus.instr_D_o); end
      checks++; if (bus.fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL rstpri_cnt got=%0d exp=0", bus.fetch_cnt_o); end
      checks++; if (bus.pc8_D_o !== 32'h3008) begin errors++; $display("FAIL rstpri_pc8 got=%h exp=%h", bus.pc8_D_o, 32'h3008); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_jr_fault();
      test_bounds();
      test_reset_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage program-counter controller and F/D pipeline register for the P5 five-stage MIPS core. It drives the PC into the instruction-fetch unit and captures the returned instruction into the F/D register. It computes the next PC from sequential, branch, jump and jump-register requests resolved in D, with one branch delay slot. Stall is supplied by the hazard unit, and a sticky fetch-fault flag is set for PCs outside instruction memory.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, instruction-memory depth in 32-bit words.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  from hazard unit; freezes PC and F/D register.
- npc_sel_D_i  in  2  0=PC+4, 1=branch, 2=j/jal, 3=jr/jalr.
- br_taken_D_i  in  1  branch comparison result for the instruction in D.
- imm16_D_i  in  16  branch offset field of instr_D.
- imm26_D_i  in  26  jump index field of instr_D.
- jr_tgt_D_i  in  32  forwarded rs value for jr/jalr.
- instr_F_i  in  32  instruction returned by the fetch unit for pc_F_o.
- pc_F_o  out  32  current fetch PC, to the fetch unit.
- instr_D_o  out  32  F/D instruction.
- pc_D_o  out  32  F/D PC.
- pc8_D_o  out  32  pc_D_o + 8, the link value for jal/jalr.
- fetch_cnt_o  out  32  count of instructions accepted into D.
- fault_o  out  1  sticky fetch fault.

## Operation
- The PC register holds pc_F_o. Redirect targets are computed from pc_D_o, which is the PC of the branch or jump, so the instruction in F is the delay slot and is never squashed.
- Next PC when not stalled:
  - sel 0: pc_F + 4.
  - sel 1 with br_taken: pc_D + 4 + (sext(imm16) << 2).
  - sel 1 without br_taken: pc_F + 4.
  - sel 2: {pc_D[31:28], imm26, 2'b00}.
  - sel 3: jr_tgt_D_i.
- All arithmetic is modulo 2^32 and wraps silently.
- F/D register, when not stalled: instr_D <= instr_F_i, pc_D <= pc_F. pc8_D_o is combinational from pc_D.
- stall_i=1: PC, F/D register and fetch_cnt hold. Any redirect presented in the same cycle is ignored; it is re-presented next cycle because D is held.
- fetch_cnt increments by 1 on every non-stall cycle after reset. At 32'hFFFF_FFFF it wraps to 0.
- Fault check on the PC being loaded: fault if pc[1:0] != 0, or pc < IM_BASE, or pc >= IM_BASE + 4*IM_WORDS.
  - On fault, fault_o sets and stays set until reset.
  - The PC still loads the offending value; no trap is taken.
  - A jr to a misaligned target is the typical case.
- Two-state control FSM:
  - RUN to FAULT on the first fault.
  - FAULT holds the current PC in addition to honouring stall, freezing fetch.
  - The F/D register keeps advancing with its last input.
  - FAULT exits only via reset.

## Timing
- Reset (synchronous):
  - pc_F_o = RESET_PC.
  - instr_D_o = 0 (nop).
  - pc_D_o = RESET_PC.
  - pc8_D_o = RESET_PC + 8.
  - fetch_cnt_o = 0.
  - fault_o = 0.
  - FSM = RUN.
- Reset overrides stall and any redirect in the same cycle.
- Instruction fetch is combinational: instr_F_i is valid in the same cycle as pc_F_o. F-to-D latency is 1 cycle.
- A redirect decided in D in cycle n gives pc_F_o = target in cycle n+1. The delay slot enters D in cycle n+1.
- pc_F_o and all registered outputs change only at the clock edge. pc8_D_o follows pc_D_o combinationally.

## Structure
- Shared package holds:
  - the npc_sel encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR);
  - RESET_PC, IM_BASE, IM_WORDS;
  - the FSM state type.
- One natural sub-module: npc_calc, which computes the combinational next-PC target.
- The PC register, F/D register, counter, fault logic and FSM live in fetch_pc_ctrl.

## Test plan
- Reset, then 3 unstalled cycles with sel 0 -> pc_F_o = 3000, 3004, 3008, 300C; fetch_cnt_o = 3; pc_D_o = 3008; pc8_D_o = 3010.
- pc_D = 3010, imm16 = 16'hFFFC, sel 1, taken -> next pc_F_o = 3004. The same case not taken -> pc_F_o + 4.
- pc_D = 3014, imm26 = 26'h0000C40, sel 2 -> next pc_F_o = 3100. instr_D_o in the following cycle is the delay-slot word fetched at 3018.
- stall_i held for 2 cycles while sel 2 is asserted -> PC, F/D and fetch_cnt frozen. The redirect takes effect in the first cycle after stall drops.
- sel 3 with jr_tgt = 3002 -> fault_o = 1 and pc_F_o = 3002, then held. fault_o stays set across later cycles and clears only after reset.
- reset asserted in the same cycle as a taken branch and stall -> pc_F_o = 3000 and all outputs at their reset values next cycle.
